id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register; sits directly upstream of the ALU, whose operand_a, operand_b and alu_control inputs it drives.
//  Captures decoded fields and selects operands from PC or immediate. Forwards operands from EX, EX/MEM and MEM/WB.
//  Detects load-use hazards, back-pressuring decode for one bubble. Valid/ready handshake on both sides; synchronous flush.
// PARAMETERS
//  XLEN    32  datapath width
//  RADDR   5   register address width
// PORTS
//  clk            in   1      clock, rising edge
//  rst_n          in   1      asynchronous reset, active low
//  flush          in   1      kill held and incoming instruction (branch/jump redirect)
//  in_valid       in   1      decode presents an instruction
//  in_ready       out  1      stage accepts (combinational)
//  in_pc          in   XLEN   instruction PC
//  in_rs1_data    in   XLEN   regfile read data rs1
//  in_rs2_data    in   XLEN   regfile read data rs2
//  in_imm         in   XLEN   sign-extended immediate
//  in_rs1_addr    in   RADDR  source 1 index
//  in_rs2_addr    in   RADDR  source 2 index
//  in_rd_addr     in   RADDR  destination index
//  in_alu_control in   4      ALU op (ADD 0000 SUB 0001 SLL 0010 SLT 0011 SLTU 0100 XOR 0101 SRL 0110 SRA 0111 OR 1000 AND 1001)
//  in_alu_src_a   in   1      0: rs1, 1: pc
//  in_alu_src_b   in   1      0: rs2, 1: imm
//  in_reg_write   in   1      instruction writes rd
//  in_mem_read    in   1      instruction is a load
//  ex_result      in   XLEN   ALU result of the instruction currently held here
//  exmem_reg_write in  1      EX/MEM writes rd;  exmem_rd_addr in RADDR;  exmem_result in XLEN
//  memwb_reg_write in  1      MEM/WB writes rd;  memwb_rd_addr in RADDR;  memwb_result in XLEN
//  out_valid      out  1      held instruction valid
//  out_ready      in   1      EX/MEM accepts
//  operand_a      out  XLEN   to ALU
//  operand_b      out  XLEN   to ALU
//  alu_control    out  4      to ALU
//  out_store_data out  XLEN   forwarded rs2 (store data)
//  out_pc         out  XLEN   held PC
//  out_rd_addr    out  RADDR  held rd
//  out_reg_write  out  1      held reg_write
//  out_mem_read   out  1      held mem_read
// BEHAVIOUR
//  Reset (rst_n low, async): all registered outputs 0 (alu_control=ADD); in_ready=0 while rst_n low.
//  Forwarding per source (rs1, rs2), applied at capture; first match wins:
//   1. EX: out_valid & out_reg_write & !out_mem_read & out_rd_addr==rsN -> ex_result
//   2. exmem_reg_write & exmem_rd_addr==rsN -> exmem_result
//   3. memwb_reg_write & memwb_rd_addr==rsN -> memwb_result
//   4. otherwise in_rsN_data. rsN==0 is never forwarded (yields in_rsN_data).
//  operand_a = src_a ? in_pc : fwd_rs1;  operand_b = src_b ? in_imm : fwd_rs2;  out_store_data = fwd_rs2, independent of src_b.
//  load_use = out_valid & out_mem_read & out_rd_addr!=0 & (out_rd_addr==in_rs1_addr | out_rd_addr==in_rs2_addr).
//   Compared regardless of src selects.
//  in_ready = rst_n & (!out_valid | out_ready) & !load_use.
//  Rising edge, priority order:
//   1. flush: out_valid<=0; incoming discarded.
//   2. in_valid & in_ready: capture; out_valid<=1.
//   3. out_ready: out_valid<=0, giving a bubble.
//   4. else hold.
//  Latency: one cycle from capture to ALU inputs. Throughput: 1 instr/cycle with no hazards.
//  Load-use: one bubble. The load drains to EX/MEM, the register empties, and the next cycle captures via exmem forwarding.
//  While out_valid & !out_ready, all payload outputs are stable.
//  Payload is updated only on capture; on flush or bubble it keeps its old value, with out_valid=0.
//  Widths: all XLEN, no extension or truncation.
// TESTING
//  1. Reset mid-stream: rst_n low while out_valid=1 -> out_valid=0, operand_a/b=0, alu_control=0000 same cycle, in_ready=0.
//  2. Back-to-back ADD x1 then SUB x2,x1,x3 (x3=5), ex_result=0x10 -> second captures operand_a=0x10, operand_b=5, alu_control=0001.
//  3. Load-use: LW x5 held, next uses x5 -> in_ready=0 one cycle; then captures exmem_result=0xDEADBEEF as operand_a.
//  4. Priority: exmem and memwb both write x7 (0x1 / 0x2), rs1=7 -> operand_a=0x1; rs1=0 with matches -> in_rs1_data.
//  5. Stall: out_ready=0 for 3 cycles -> payload constant, in_ready=0; flush during stall -> out_valid=0 next edge, incoming dropped.
//  6. src selects: src_a=1 pc=0x100, src_b=1 imm=0xFFFFFFFC -> operand_a=0x100, operand_b=0xFFFFFFFC, out_store_data=fwd rs2.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register in front of the ALU. It selects operands, forwards results from later stages,
// and stalls decode on a load-use hazard. Capture-to-ALU latency is one cycle.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_rs1_data,
  input  logic [XLEN-1:0]  in_rs2_data,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [RADDR-1:0] in_rs1_addr,
  input  logic [RADDR-1:0] in_rs2_addr,
  input  logic [RADDR-1:0] in_rd_addr,
  input  logic [3:0]       in_alu_control,
  input  logic             in_alu_src_a,
  input  logic             in_alu_src_b,
  input  logic             in_reg_write,
  input  logic             in_mem_read,
  input  logic [XLEN-1:0]  ex_result,
  input  logic             exmem_reg_write,
  input  logic [RADDR-1:0] exmem_rd_addr,
  input  logic [XLEN-1:0]  exmem_result,
  input  logic             memwb_reg_write,
  input  logic [RADDR-1:0] memwb_rd_addr,
  input  logic [XLEN-1:0]  memwb_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  operand_a,
  output logic [XLEN-1:0]  operand_b,
  output logic [3:0]       alu_control,
  output logic [XLEN-1:0]  out_store_data,
  output logic [XLEN-1:0]  out_pc,
  output logic [RADDR-1:0] out_rd_addr,
  output logic             out_reg_write,
  output logic             out_mem_read
);

  logic             valid_q, valid_d;
  logic [XLEN-1:0]  op_a_q, op_a_d;
  logic [XLEN-1:0]  op_b_q, op_b_d;
  logic [3:0]       alu_ctrl_q, alu_ctrl_d;
  logic [XLEN-1:0]  store_q, store_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [RADDR-1:0] rd_q, rd_d;
  logic             reg_write_q, reg_write_d;
  logic             mem_read_q, mem_read_d;

  logic             ex_fwd_en;
  logic             load_use;
  logic [XLEN-1:0]  fwd_rs1, fwd_rs2;

  // A held load has no result yet, so it cannot feed EX forwarding; load_use covers that case.
  assign ex_fwd_en = valid_q & reg_write_q & ~mem_read_q;

  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [RADDR-1:0] rs,
    input logic [XLEN-1:0]  rf_data,
    input logic             ex_en,
    input logic [RADDR-1:0] ex_rd,
    input logic [XLEN-1:0]  ex_val,
    input logic             em_en,
    input logic [RADDR-1:0] em_rd,
    input logic [XLEN-1:0]  em_val,
    input logic             mw_en,
    input logic [RADDR-1:0] mw_rd,
    input logic [XLEN-1:0]  mw_val
  );
    logic [XLEN-1:0] r;
    r = rf_data;
    if (rs != '0) begin
      if (ex_en && ex_rd == rs)      r = ex_val;
      else if (em_en && em_rd == rs) r = em_val;
      else if (mw_en && mw_rd == rs) r = mw_val;
    end
    return r;
  endfunction

  assign fwd_rs1 = fwd_sel(in_rs1_addr, in_rs1_data, ex_fwd_en, rd_q, ex_result,
                           exmem_reg_write, exmem_rd_addr, exmem_result,
                           memwb_reg_write, memwb_rd_addr, memwb_result);
  assign fwd_rs2 = fwd_sel(in_rs2_addr, in_rs2_data, ex_fwd_en, rd_q, ex_result,
                           exmem_reg_write, exmem_rd_addr, exmem_result,
                           memwb_reg_write, memwb_rd_addr, memwb_result);

  assign load_use = valid_q & mem_read_q & (rd_q != '0) &
                    ((rd_q == in_rs1_addr) | (rd_q == in_rs2_addr));

  assign in_ready = rst_n & (~valid_q | out_ready) & ~load_use;

  always_comb begin
    valid_d     = valid_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    alu_ctrl_d  = alu_ctrl_q;
    store_d     = store_q;
    pc_d        = pc_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_valid && in_ready) begin
      valid_d     = 1'b1;
      op_a_d      = in_alu_src_a ? in_pc  : fwd_rs1;
      op_b_d      = in_alu_src_b ? in_imm : fwd_rs2;
      alu_ctrl_d  = in_alu_control;
      store_d     = fwd_rs2;
      pc_d        = in_pc;
      rd_d        = in_rd_addr;
      reg_write_d = in_reg_write;
      mem_read_d  = in_mem_read;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      alu_ctrl_q  <= 4'b0000;
      store_q     <= '0;
      pc_q        <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      alu_ctrl_q  <= alu_ctrl_d;
      store_q     <= store_d;
      pc_q        <= pc_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
    end
  end

  assign out_valid      = valid_q;
  assign operand_a      = op_a_q;
  assign operand_b      = op_b_q;
  assign alu_control    = alu_ctrl_q;
  assign out_store_data = store_q;
  assign out_pc         = pc_q;
  assign out_rd_addr    = rd_q;
  assign out_reg_write  = reg_write_q;
  assign out_mem_read   = mem_read_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: forwarding, load-use, stall, flush, src selects and async reset.
module tb_id_ex_stage;

  logic        clk, rst_n, flush, in_valid, in_ready;
  logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [3:0]  in_alu_control;
  logic        in_alu_src_a, in_alu_src_b, in_reg_write, in_mem_read;
  logic [31:0] ex_result;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd_addr, memwb_rd_addr;
  logic [31:0] exmem_result, memwb_result;
  logic        out_valid, out_ready;
  logic [31:0] operand_a, operand_b, out_store_data, out_pc;
  logic [3:0]  alu_control;
  logic [4:0]  out_rd_addr;
  logic        out_reg_write, out_mem_read;

  int n_assert = 0;
  int n_fail   = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_alu_control(in_alu_control), .in_alu_src_a(in_alu_src_a), .in_alu_src_b(in_alu_src_b),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .ex_result(ex_result),
    .exmem_reg_write(exmem_reg_write), .exmem_rd_addr(exmem_rd_addr), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd_addr(memwb_rd_addr), .memwb_result(memwb_result),
    .out_valid(out_valid), .out_ready(out_ready), .operand_a(operand_a), .operand_b(operand_b),
    .alu_control(alu_control), .out_store_data(out_store_data), .out_pc(out_pc),
    .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    if (obs !== expv) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [31:0] pc, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] imm, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] rd, input logic [3:0] ctrl, input logic sa,
                       input logic sb, input logic rw, input logic mr);
    in_pc = pc; in_rs1_data = d1; in_rs2_data = d2; in_imm = imm;
    in_rs1_addr = a1; in_rs2_addr = a2; in_rd_addr = rd; in_alu_control = ctrl;
    in_alu_src_a = sa; in_alu_src_b = sb; in_reg_write = rw; in_mem_read = mr;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    ex_result = 32'h0;
    exmem_reg_write = 1'b0; exmem_rd_addr = 5'd0; exmem_result = 32'h0;
    memwb_reg_write = 1'b0; memwb_rd_addr = 5'd0; memwb_result = 32'h0;
    #2;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_alu_control", alu_control, 4'b0000);
    #5 rst_n = 1'b1;
    #1;
    chk("idle_in_ready", in_ready, 1'b1);

    // ADD x1, x2, x3
    in_valid = 1'b1;
    instr(32'h40, 32'h7, 32'h9, 32'h0, 5'd2, 5'd3, 5'd1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("add_valid", out_valid, 1'b1);
    chk("add_op_a", operand_a, 32'h7);
    chk("add_op_b", operand_b, 32'h9);
    chk("add_rd", out_rd_addr, 5'd1);

    // SUB x2, x1, x3 with x1 forwarded from EX
    instr(32'h44, 32'h99, 32'h5, 32'h0, 5'd1, 5'd3, 5'd2, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0);
    ex_result = 32'h10;
    #1;
    chk("sub_in_ready", in_ready, 1'b1);
    tick();
    chk("sub_op_a_ex_fwd", operand_a, 32'h10);
    chk("sub_op_b", operand_b, 32'h5);
    chk("sub_alu_control", alu_control, 4'b0001);

    // LW x5, 4(x2), x2 forwarded from EX
    instr(32'h48, 32'h1000, 32'h0, 32'h4, 5'd2, 5'd0, 5'd5, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1);
    ex_result = 32'h2000;
    tick();
    chk("lw_op_a", operand_a, 32'h2000);
    chk("lw_op_b", operand_b, 32'h4);
    chk("lw_mem_read", out_mem_read, 1'b1);

    // ADD x6, x5, x0 -> load-use bubble
    instr(32'h4C, 32'h55, 32'h3, 32'h0, 5'd5, 5'd0, 5'd6, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    ex_result = 32'h5555;
    #1;
    chk("lu_in_ready", in_ready, 1'b0);
    tick();
    chk("lu_bubble_valid", out_valid, 1'b0);
    chk("lu_bubble_payload", operand_a, 32'h2000);
    exmem_reg_write = 1'b1; exmem_rd_addr = 5'd5; exmem_result = 32'hDEADBEEF;
    #1;
    chk("lu_resume_ready", in_ready, 1'b1);
    tick();
    chk("lu_valid", out_valid, 1'b1);
    chk("lu_op_a_exmem", operand_a, 32'hDEADBEEF);
    chk("lu_op_b_x0", operand_b, 32'h3);

    // Priority: exmem over memwb on rs1=7; EX over exmem on rs2=8
    instr(32'h50, 32'h77, 32'h66, 32'h0, 5'd7, 5'd0, 5'd8, 4'b0101, 1'b0, 1'b0, 1'b1, 1'b0);
    exmem_rd_addr = 5'd7; exmem_result = 32'h1;
    memwb_reg_write = 1'b1; memwb_rd_addr = 5'd7; memwb_result = 32'h2;
    tick();
    chk("prio_exmem_over_memwb", operand_a, 32'h1);
    chk("prio_xor_ctrl", alu_control, 4'b0101);
    instr(32'h54, 32'h77, 32'h66, 32'h0, 5'd7, 5'd8, 5'd0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    exmem_rd_addr = 5'd8; exmem_result = 32'h1;
    ex_result = 32'h88;
    tick();
    chk("prio_memwb_only", operand_a, 32'h2);
    chk("prio_ex_over_exmem", operand_b, 32'h88);
    chk("prio_ex_store", out_store_data, 32'h88);

    // x0 never forwarded even when EX, exmem and memwb all target rd=0
    instr(32'h58, 32'h1234, 32'h5678, 32'h0, 5'd0, 5'd0, 5'd9, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    exmem_rd_addr = 5'd0; memwb_rd_addr = 5'd0; ex_result = 32'hBAD;
    tick();
    chk("x0_op_a", operand_a, 32'h1234);
    chk("x0_op_b", operand_b, 32'h5678);

    // Source selects: pc / imm, store data still forwarded rs2
    instr(32'h100, 32'h11, 32'hABCD, 32'hFFFFFFFC, 5'd3, 5'd4, 5'd10, 4'b1001, 1'b1, 1'b1, 1'b1, 1'b0);
    exmem_rd_addr = 5'd4; exmem_result = 32'hCAFE; memwb_reg_write = 1'b0;
    tick();
    chk("src_op_a_pc", operand_a, 32'h100);
    chk("src_op_b_imm", operand_b, 32'hFFFFFFFC);
    chk("src_store_fwd", out_store_data, 32'hCAFE);
    chk("src_out_pc", out_pc, 32'h100);
    exmem_reg_write = 1'b0;

    // Stall 3 cycles, then flush during stall
    out_ready = 1'b0;
    instr(32'h104, 32'h333, 32'h444, 32'h0, 5'd1, 5'd2, 5'd11, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", in_ready, 1'b0);
      tick();
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_op_a", operand_a, 32'h100);
      chk("stall_alu_control", alu_control, 4'b1001);
    end
    flush = 1'b1;
    tick();
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_payload", operand_a, 32'h100);
    #1;
    chk("flush_ready_after", in_ready, 1'b1);
    tick();
    chk("flush_drop_incoming", out_valid, 1'b0);
    chk("flush_drop_payload", operand_a, 32'h100);
    flush = 1'b0; out_ready = 1'b1;
    tick();
    chk("post_flush_valid", out_valid, 1'b1);
    chk("post_flush_op_a", operand_a, 32'h333);
    chk("post_flush_op_b", operand_b, 32'h444);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", out_valid, 1'b0);
    chk("drain_payload", operand_a, 32'h333);

    // Async reset while holding a valid instruction
    in_valid = 1'b1;
    instr(32'h200, 32'hAA, 32'hBB, 32'h0, 5'd1, 5'd2, 5'd3, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("pre_rst_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_op_a", operand_a, 32'h0);
    chk("mid_rst_op_b", operand_b, 32'h0);
    chk("mid_rst_alu_control", alu_control, 4'b0000);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    chk("mid_rst_pc", out_pc, 32'h0);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_valid", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
